// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI PHY responder: FSM states, TX CMD
// types, register map, reset values and set/clear alias offsets.
package ulpi_pkg;

  typedef enum logic [3:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_W_ACK,
    ST_W_DATA,
    ST_W_STP,
    ST_R_ACK,
    ST_R_TURN,
    ST_R_DATA,
    ST_RX_TURN,
    ST_RX_DATA,
    ST_TX_DATA,
    ST_PHY_RST
  } ulpi_state_e;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_TX   = 2'b01;
  localparam logic [1:0] CMD_REGW = 2'b10;
  localparam logic [1:0] CMD_REGR = 2'b11;

  localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;
  localparam logic [5:0] ADDR_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] ADDR_SCRATCH   = 6'h16;

  localparam logic [7:0] RST_FUNC_CTRL = 8'h41;
  localparam logic [7:0] RST_OTG_CTRL  = 8'h06;
  localparam logic [7:0] RST_SCRATCH   = 8'h00;

  localparam logic [5:0] OFS_SET = 6'd1;
  localparam logic [5:0] OFS_CLR = 6'd2;

  localparam int FUNC_RESET_BIT = 5;

  function automatic logic [1:0] cmd_type(input logic [7:0] cmd_byte);
    return cmd_byte[7:6];
  endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// ULPI register file: FUNC_CTRL, OTG_CTRL, SCRATCH with write port, read mux
// and restore-to-default. Set/clear aliases exist only with ULPI_PHY_SETCLR_EN.
module ulpi_phy_regfile
  import ulpi_pkg::*;
(
  input  logic       clk,
  input  logic       restore,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       func_rst_req,
  output logic [7:0] func_ctrl,
  output logic [7:0] otg_ctrl
);

  logic [7:0] scratch;
  logic       func_wr;
  logic       otg_wr;
  logic       scratch_wr;
  logic [7:0] func_nxt;
  logic [7:0] otg_nxt;

  always_comb begin
    func_wr    = 1'b0;
    otg_wr     = 1'b0;
    scratch_wr = 1'b0;
    func_nxt   = func_ctrl;
    otg_nxt    = otg_ctrl;
    if (wr_en) begin
      if (wr_addr == ADDR_FUNC_CTRL) begin
        func_wr  = 1'b1;
        func_nxt = wr_data;
      end
      if (wr_addr == ADDR_OTG_CTRL) begin
        otg_wr  = 1'b1;
        otg_nxt = wr_data;
      end
      if (wr_addr == ADDR_SCRATCH) begin
        scratch_wr = 1'b1;
      end
`ifdef ULPI_PHY_SETCLR_EN
      if (wr_addr == ADDR_FUNC_CTRL + OFS_SET) begin
        func_wr  = 1'b1;
        func_nxt = func_ctrl | wr_data;
      end
      if (wr_addr == ADDR_FUNC_CTRL + OFS_CLR) begin
        func_wr  = 1'b1;
        func_nxt = func_ctrl & ~wr_data;
      end
      if (wr_addr == ADDR_OTG_CTRL + OFS_SET) begin
        otg_wr  = 1'b1;
        otg_nxt = otg_ctrl | wr_data;
      end
      if (wr_addr == ADDR_OTG_CTRL + OFS_CLR) begin
        otg_wr  = 1'b1;
        otg_nxt = otg_ctrl & ~wr_data;
      end
`endif
    end
  end

  // A write leaving the reset bit set sends the FSM into its PHY reset hold.
  assign func_rst_req = func_wr & func_nxt[FUNC_RESET_BIT];

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_FUNC_CTRL: rd_data = func_ctrl;
      ADDR_OTG_CTRL:  rd_data = otg_ctrl;
      ADDR_SCRATCH:   rd_data = scratch;
      default:        rd_data = 8'h00;
    endcase
`ifdef ULPI_PHY_SETCLR_EN
    if ((rd_addr == ADDR_FUNC_CTRL + OFS_SET) || (rd_addr == ADDR_FUNC_CTRL + OFS_CLR)) begin
      rd_data = func_ctrl;
    end
    if ((rd_addr == ADDR_OTG_CTRL + OFS_SET) || (rd_addr == ADDR_OTG_CTRL + OFS_CLR)) begin
      rd_data = otg_ctrl;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (restore) begin
      func_ctrl <= RST_FUNC_CTRL;
      otg_ctrl  <= RST_OTG_CTRL;
      scratch   <= RST_SCRATCH;
    end else begin
      if (func_wr)    func_ctrl <= func_nxt;
      if (otg_wr)     otg_ctrl  <= otg_nxt;
      if (scratch_wr) scratch   <= wr_data;
    end
  end

endmodule

// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI model: start-up DIR hold, TX CMD handling with NXT handshakes,
// RX CMDs on line-state change. Optional set/clear aliases: ULPI_PHY_SETCLR_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// STARTUP    | DIR held high for RESET_CYCLES after RST
// IDLE       | link owns bus; decode TX CMD or issue pending RX CMD
// W_ACK      | register write cmd acknowledged (NXT=1)
// W_DATA     | register write data accepted (NXT=1)
// W_STP      | waiting for STP to commit the write
// R_ACK      | register read cmd acknowledged (NXT=1)
// R_TURN     | turnaround to PHY ownership
// R_DATA     | PHY drives register value
// RX_TURN    | turnaround before RX CMD
// RX_DATA    | PHY drives RX CMD {RXCMD_HI, line state}
// TX_DATA    | transmit payload, NXT=1, bytes counted until STP
// PHY_RST    | DIR held high for RESET_CYCLES after FUNC_CTRL.Reset write
module ulpi_phy_responder
  import ulpi_pkg::*;
#(
  parameter int         RESET_CYCLES = 16,
  parameter logic [5:0] RXCMD_HI     = 6'b010101
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  ULPI_DATA_IN,
  input  logic        ULPI_STP,
  output logic [7:0]  ULPI_DATA_OUT,
  output logic        ULPI_DATA_OE,
  output logic        ULPI_DIR,
  output logic        ULPI_NXT,
  input  logic [1:0]  LINESTATE,
  output logic [7:0]  FUNC_CTRL,
  output logic [7:0]  OTG_CTRL,
  output logic [15:0] TX_BYTES,
  output logic        TX_ACTIVE
);

  localparam int              CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_CYCLES - 1);

  ulpi_state_e      state;
  ulpi_state_e      next_state;
  logic [CNT_W-1:0] rst_cnt;
  logic [5:0]       addr_q;
  logic [7:0]       wr_data_q;
  logic [1:0]       ls_rep;
  logic             rx_pending;
  logic             rx_event;
  logic [15:0]      tx_cnt;
  logic             dir_d;
  logic             nxt_d;
  logic             oe_d;
  logic             rf_wr_en;
  logic             rf_restore;
  logic             func_rst_req;
  logic [7:0]       rd_data;

  assign rx_event   = rx_pending | (LINESTATE != ls_rep);
  assign rf_wr_en   = (state == ST_W_STP) && ULPI_STP;
  assign rf_restore = RST | ((state == ST_PHY_RST) && (rst_cnt == '0));

  ulpi_phy_regfile u_regfile (
    .clk          (CLK),
    .restore      (rf_restore),
    .wr_en        (rf_wr_en),
    .wr_addr      (addr_q),
    .wr_data      (wr_data_q),
    .rd_addr      (addr_q),
    .rd_data      (rd_data),
    .func_rst_req (func_rst_req),
    .func_ctrl    (FUNC_CTRL),
    .otg_ctrl     (OTG_CTRL)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_STARTUP;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_STARTUP, ST_PHY_RST: if (rst_cnt == '0) next_state = ST_IDLE;
      ST_IDLE: begin
        // A pending RX CMD wins over a coincident TX CMD; the link retries.
        if (rx_event) begin
          next_state = ST_RX_TURN;
        end else if (ULPI_DATA_IN != 8'h00) begin
          case (cmd_type(ULPI_DATA_IN))
            CMD_REGW: next_state = ST_W_ACK;
            CMD_REGR: next_state = ST_R_ACK;
            CMD_TX:   next_state = ST_TX_DATA;
            CMD_IDLE: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
          endcase
        end
      end
      ST_W_ACK:   next_state = ULPI_STP ? ST_IDLE : ST_W_DATA;
      ST_W_DATA:  next_state = ULPI_STP ? ST_IDLE : ST_W_STP;
      ST_W_STP:   if (ULPI_STP) next_state = func_rst_req ? ST_PHY_RST : ST_IDLE;
      ST_R_ACK:   next_state = ST_R_TURN;
      ST_R_TURN:  next_state = ST_R_DATA;
      ST_R_DATA:  next_state = ST_IDLE;
      ST_RX_TURN: next_state = ST_RX_DATA;
      ST_RX_DATA: next_state = ST_IDLE;
      ST_TX_DATA: if (ULPI_STP) next_state = ST_IDLE;
      default:    next_state = ST_STARTUP;
    endcase
  end

  // Bus pins are decoded from next_state so they are registered yet line up
  // with the state they belong to.
  always_comb begin
    dir_d = 1'b0;
    nxt_d = 1'b0;
    oe_d  = 1'b0;
    case (next_state)
      ST_STARTUP, ST_PHY_RST, ST_R_TURN, ST_RX_TURN: dir_d = 1'b1;
      ST_R_DATA, ST_RX_DATA: begin
        dir_d = 1'b1;
        oe_d  = 1'b1;
      end
      ST_W_ACK, ST_W_DATA, ST_R_ACK, ST_TX_DATA: nxt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ULPI_DIR      <= 1'b1;
      ULPI_NXT      <= 1'b0;
      ULPI_DATA_OE  <= 1'b0;
      ULPI_DATA_OUT <= 8'h00;
      TX_ACTIVE     <= 1'b0;
      TX_BYTES      <= 16'h0000;
      tx_cnt        <= 16'h0000;
      rst_cnt       <= CNT_INIT;
      addr_q        <= 6'h00;
      wr_data_q     <= 8'h00;
      ls_rep        <= LINESTATE;
      rx_pending    <= 1'b0;
    end else begin
      ULPI_DIR     <= dir_d;
      ULPI_NXT     <= nxt_d;
      ULPI_DATA_OE <= oe_d;
      TX_ACTIVE    <= (next_state == ST_TX_DATA);

      if ((state != ST_PHY_RST) && (next_state == ST_PHY_RST)) rst_cnt <= CNT_INIT;
      else if (rst_cnt != '0)                                  rst_cnt <= rst_cnt - CNT_W'(1);

      if (state == ST_IDLE)   addr_q    <= ULPI_DATA_IN[5:0];
      if (state == ST_W_DATA) wr_data_q <= ULPI_DATA_IN;

      if (state == ST_IDLE) begin
        tx_cnt <= 16'h0000;
      end else if (state == ST_TX_DATA) begin
        if (ULPI_STP)                TX_BYTES <= tx_cnt;
        else if (tx_cnt != 16'hFFFF) tx_cnt   <= tx_cnt + 16'd1;
      end

      case (next_state)
        ST_R_DATA:  ULPI_DATA_OUT <= rd_data;
        ST_RX_DATA: ULPI_DATA_OUT <= {RXCMD_HI, LINESTATE};
        default:    ULPI_DATA_OUT <= 8'h00;
      endcase

      if (next_state == ST_RX_DATA) ls_rep <= LINESTATE;

      // A fresh change wins over the clear so nothing seen during RX_DATA is lost.
      if (LINESTATE != ls_rep)     rx_pending <= 1'b1;
      else if (state == ST_RX_DATA) rx_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Directed self-checking bench for ulpi_phy_responder: register transaction
// table plus hand-written reset, RX CMD, abort, transmit and PHY reset cases.
module tb_ulpi_phy_responder;
  import ulpi_pkg::*;

`ifdef ULPI_PHY_SETCLR_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  ULPI_DATA_IN;
  logic        ULPI_STP;
  logic [7:0]  ULPI_DATA_OUT;
  logic        ULPI_DATA_OE;
  logic        ULPI_DIR;
  logic        ULPI_NXT;
  logic [1:0]  LINESTATE;
  logic [7:0]  FUNC_CTRL;
  logic [7:0]  OTG_CTRL;
  logic [15:0] TX_BYTES;
  logic        TX_ACTIVE;

  int n_pass   = 0;
  int n_checks = 0;

  ulpi_phy_responder dut (
    .CLK           (CLK),
    .RST           (RST),
    .ULPI_DATA_IN  (ULPI_DATA_IN),
    .ULPI_STP      (ULPI_STP),
    .ULPI_DATA_OUT (ULPI_DATA_OUT),
    .ULPI_DATA_OE  (ULPI_DATA_OE),
    .ULPI_DIR      (ULPI_DIR),
    .ULPI_NXT      (ULPI_NXT),
    .LINESTATE     (LINESTATE),
    .FUNC_CTRL     (FUNC_CTRL),
    .OTG_CTRL      (OTG_CTRL),
    .TX_BYTES      (TX_BYTES),
    .TX_ACTIVE     (TX_ACTIVE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       is_write;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_func;
    logic [7:0] exp_otg;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2:0] pins();
    return {ULPI_DIR, ULPI_NXT, ULPI_DATA_OE};
  endfunction

  // Count consecutive DIR-high cycles starting with the current one.
  task automatic count_dir(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ULPI_DIR) break;
      n++;
      step();
    end
  endtask

  // Drives cmd in the current cycle T; returns in the cycle after STP.
  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input string tag);
    ULPI_DATA_IN = cmd;
    step();
    check({tag, ".w_ack"}, pins(), 3'b010);
    ULPI_DATA_IN = 8'h00;
    step();
    check({tag, ".w_data"}, pins(), 3'b010);
    ULPI_DATA_IN = data;
    step();
    check({tag, ".w_stp"}, pins(), 3'b000);
    ULPI_DATA_IN = 8'h00;
    ULPI_STP     = 1'b1;
    step();
    ULPI_STP = 1'b0;
  endtask

  // Drives cmd in cycle T; returns in cycle T+4.
  task automatic do_read(input logic [7:0] cmd, input logic [7:0] exp, input string tag);
    ULPI_DATA_IN = cmd;
    step();
    check({tag, ".r_ack"}, pins(), 3'b010);
    ULPI_DATA_IN = 8'h00;
    step();
    check({tag, ".r_turn"}, pins(), 3'b100);
    step();
    check({tag, ".r_data_pins"}, pins(), 3'b101);
    check({tag, ".r_data"}, ULPI_DATA_OUT, exp);
    step();
    check({tag, ".r_done"}, pins(), 3'b000);
  endtask

  initial begin
    int n;
    int nxt_cyc;
    int act_cyc;

    vecs[0]  = '{1'b1, 8'h8C, 8'h04, 8'h00, 8'h41, SC ? 8'h02 : 8'h06};
    vecs[1]  = '{1'b0, 8'hCC, 8'h00, SC ? 8'h02 : 8'h00, 8'h41, SC ? 8'h02 : 8'h06};
    vecs[2]  = '{1'b1, 8'h8A, 8'h55, 8'h00, 8'h41, 8'h55};
    vecs[3]  = '{1'b0, 8'hC4, 8'h00, 8'h41, 8'h41, 8'h55};
    vecs[4]  = '{1'b0, 8'hCA, 8'h00, 8'h55, 8'h41, 8'h55};
    vecs[5]  = '{1'b1, 8'h96, 8'hA5, 8'h00, 8'h41, 8'h55};
    vecs[6]  = '{1'b0, 8'hD6, 8'h00, 8'hA5, 8'h41, 8'h55};
    vecs[7]  = '{1'b1, 8'h9F, 8'hFF, 8'h00, 8'h41, 8'h55};
    vecs[8]  = '{1'b0, 8'hDF, 8'h00, 8'h00, 8'h41, 8'h55};
    vecs[9]  = '{1'b1, 8'h8B, 8'h0A, 8'h00, 8'h41, SC ? 8'h5F : 8'h55};
    vecs[10] = '{1'b0, 8'hCB, 8'h00, SC ? 8'h5F : 8'h00, 8'h41, SC ? 8'h5F : 8'h55};
    vecs[11] = '{1'b1, 8'h84, 8'h49, 8'h00, 8'h49, SC ? 8'h5F : 8'h55};
    vecs[12] = '{1'b0, 8'hC4, 8'h00, 8'h49, 8'h49, SC ? 8'h5F : 8'h55};

    RST          = 1'b1;
    ULPI_DATA_IN = 8'h00;
    ULPI_STP     = 1'b0;
    LINESTATE    = 2'b00;
    repeat (3) step();
    check("rst.pins", pins(), 3'b100);
    check("rst.data_out", ULPI_DATA_OUT, 8'h00);
    check("rst.tx", {TX_ACTIVE, TX_BYTES}, 17'h0);
    check("rst.regs", {FUNC_CTRL, OTG_CTRL}, 16'h4106);

    RST = 1'b0;
    count_dir(n);
    check("startup.dir_cycles", n, 16);
    check("startup.idle_pins", pins(), 3'b000);
    check("startup.func", FUNC_CTRL, 8'h41);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_write) do_write(vecs[i].cmd, vecs[i].data, $sformatf("vec%0d", i));
      else do_read(vecs[i].cmd, vecs[i].exp_rd, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.idle", i), pins(), 3'b000);
      check($sformatf("vec%0d.func", i), FUNC_CTRL, vecs[i].exp_func);
      check($sformatf("vec%0d.otg", i), OTG_CTRL, vecs[i].exp_otg);
    end

    // FUNC_CTRL reset bit: DIR hold, then all registers back to defaults.
    do_write(8'h84, 8'h65, "phyrst");
    check("phyrst.func_written", FUNC_CTRL, 8'h65);
    count_dir(n);
    check("phyrst.dir_cycles", n, 16);
    check("phyrst.regs", {FUNC_CTRL, OTG_CTRL}, 16'h4106);
    do_read(8'hD6, 8'h00, "phyrst.scratch");

    // Line-state change in IDLE.
    LINESTATE = 2'b10;
    step();
    check("rx.turn", pins(), 3'b100);
    step();
    check("rx.data_pins", pins(), 3'b101);
    check("rx.cmd", ULPI_DATA_OUT, 8'h56);
    step();
    check("rx.done", pins(), 3'b000);
    repeat (3) step();
    check("rx.no_repeat", pins(), 3'b000);

    // Change coinciding with a write cmd: RX CMD first, write dropped.
    LINESTATE    = 2'b00;
    ULPI_DATA_IN = 8'h8A;
    step();
    check("coin.turn", pins(), 3'b100);
    ULPI_DATA_IN = 8'h77;
    step();
    check("coin.data_pins", pins(), 3'b101);
    check("coin.cmd", ULPI_DATA_OUT, 8'h54);
    ULPI_DATA_IN = 8'h00;
    step();
    check("coin.done", pins(), 3'b000);
    step();
    check("coin.dropped", {ULPI_NXT, OTG_CTRL}, 9'h006);
    do_write(8'h8A, 8'h77, "coin.retry");
    check("coin.retry_otg", OTG_CTRL, 8'h77);

    // STP in W_ACK aborts.
    ULPI_DATA_IN = 8'h8A;
    step();
    ULPI_DATA_IN = 8'h00;
    ULPI_STP     = 1'b1;
    step();
    ULPI_STP = 1'b0;
    check("abort_ack.idle", pins(), 3'b000);
    step();
    check("abort_ack.otg", OTG_CTRL, 8'h77);

    // STP in W_DATA aborts.
    ULPI_DATA_IN = 8'h8A;
    step();
    ULPI_DATA_IN = 8'h00;
    step();
    ULPI_DATA_IN = 8'h11;
    ULPI_STP     = 1'b1;
    step();
    ULPI_DATA_IN = 8'h00;
    ULPI_STP     = 1'b0;
    check("abort_data.idle", pins(), 3'b000);
    step();
    check("abort_data.otg", OTG_CTRL, 8'h77);

    // W_STP waits; a line-state change meanwhile is held until IDLE.
    ULPI_DATA_IN = 8'h8A;
    step();
    ULPI_DATA_IN = 8'h00;
    step();
    ULPI_DATA_IN = 8'h33;
    step();
    ULPI_DATA_IN = 8'h00;
    LINESTATE    = 2'b01;
    repeat (20) step();
    check("wstp.wait_pins", pins(), 3'b000);
    check("wstp.wait_otg", OTG_CTRL, 8'h77);
    ULPI_STP = 1'b1;
    step();
    ULPI_STP = 1'b0;
    check("wstp.commit", {pins(), OTG_CTRL}, {3'b000, 8'h33});
    step();
    check("wstp.rx_turn", pins(), 3'b100);
    step();
    check("wstp.rx_cmd", {pins(), ULPI_DATA_OUT}, {3'b101, 8'h55});
    step();
    check("wstp.rx_done", pins(), 3'b000);

    // Transmit of five bytes.
    ULPI_DATA_IN = 8'h40;
    nxt_cyc = 0;
    act_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ULPI_NXT) nxt_cyc++;
      if (TX_ACTIVE) act_cyc++;
      ULPI_DATA_IN = (i < 5) ? 8'(8'hA0 + i) : 8'h00;
      ULPI_STP     = (i == 5);
    end
    step();
    ULPI_STP = 1'b0;
    check("tx.nxt_cycles", nxt_cyc, 6);
    check("tx.active_cycles", act_cyc, 6);
    check("tx.bytes", TX_BYTES, 16'd5);
    check("tx.idle", {pins(), TX_ACTIVE}, 4'b0000);

    // Transmit with STP on the first cycle counts nothing.
    ULPI_DATA_IN = 8'h41;
    step();
    ULPI_DATA_IN = 8'h00;
    ULPI_STP     = 1'b1;
    step();
    ULPI_STP = 1'b0;
    check("tx0.bytes", TX_BYTES, 16'd0);

    // RST in the middle of a read.
    ULPI_DATA_IN = 8'hC4;
    step();
    ULPI_DATA_IN = 8'h00;
    RST          = 1'b1;
    step();
    check("midrst.pins", pins(), 3'b100);
    check("midrst.regs", {FUNC_CTRL, OTG_CTRL, TX_BYTES}, {16'h4106, 16'h0000});
    RST = 1'b0;
    count_dir(n);
    check("midrst.dir_cycles", n, 16);
    check("midrst.idle", pins(), 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
